// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer for an 8-bit LS161-based program counter.
// Drives PC count/load/clear controls and latches opcode and immediate bytes.
module pc_sequencer #(
  parameter logic [7:0] HALT_OP = 8'h7F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] romData,
  input  logic       flagZ,
  input  logic       flagC,
  input  logic       stall,
  output logic       assertRom,
  output logic       doJumpBar,
  output logic       pcResetBar,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic       execStrobe,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPERAND = 2'd1,
    S_EXEC    = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;
  logic       is_jump;
  logic       cond_met;
  logic       active;

  // Stall and reset both freeze the sequence; reset additionally clears it.
  assign active     = !reset && !stall;
  assign is_jump    = (ir_q[7:6] == 2'b11);
  assign pcResetBar = ~reset;
  assign ir         = ir_q;
  assign operand    = operand_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cond_met = 1'b1;
    unique case (ir_q[5:4])
      2'b00: cond_met = 1'b1;
      2'b01: cond_met = flagZ;
      2'b10: cond_met = flagC;
      2'b11: cond_met = !flagZ;
      default: cond_met = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    operand_d  = operand_q;
    assertRom  = 1'b0;
    doJumpBar  = 1'b1;
    execStrobe = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (active) begin
          assertRom = 1'b1;
          ir_d      = romData;
          if (romData == HALT_OP) state_d = S_HALT;
          else if (romData[7])    state_d = S_OPERAND;
          else                    state_d = S_EXEC;
        end
      end
      S_OPERAND: begin
        if (active) begin
          assertRom = 1'b1;
          operand_d = romData;
          if (is_jump) begin
            // A taken jump loads the target byte; load overrides count in the PC.
            doJumpBar = !cond_met;
            state_d   = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (active) begin
          execStrobe = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_HALT: begin
        halted = !reset;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a ROM and a behavioural LS161-pair PC.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, flagZ, flagC, stall;
  logic [7:0] romData;
  logic       assertRom, doJumpBar, pcResetBar, execStrobe, halted;
  logic [7:0] ir, operand;
  logic [7:0] pc;
  logic [7:0] rom [256];
  int total = 0;
  int bad = 0;

  pc_sequencer #(.HALT_OP(8'h7F)) dut (
    .clk(clk), .reset(reset), .romData(romData), .flagZ(flagZ), .flagC(flagC),
    .stall(stall), .assertRom(assertRom), .doJumpBar(doJumpBar),
    .pcResetBar(pcResetBar), .ir(ir), .operand(operand),
    .execStrobe(execStrobe), .halted(halted)
  );

  always #5 clk = ~clk;

  // PC environment: clear beats load, load beats count.
  assign romData = rom[pc];
  always @(posedge clk) begin
    if (!pcResetBar)     pc <= 8'h00;
    else if (!doJumpBar) pc <= romData;
    else if (assertRom)  pc <= pc + 8'h01;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Holds reset two cycles, releases it; returns sampled in the first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; flagZ = 1'b0; flagC = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[8'h00] = 8'h05; rom[8'h01] = 8'h7F;
    reset = 1'b1; stall = 1'b0; flagZ = 1'b0; flagC = 1'b0;
    step(); step();
    total++; if (assertRom !== 1'b0) begin bad++; $display("FAIL rst_assertRom got=%b exp=0", assertRom); end
    total++; if (doJumpBar !== 1'b1) begin bad++; $display("FAIL rst_doJumpBar got=%b exp=1", doJumpBar); end
    total++; if (pcResetBar !== 1'b0) begin bad++; $display("FAIL rst_pcResetBar got=%b exp=0", pcResetBar); end
    total++; if (execStrobe !== 1'b0) begin bad++; $display("FAIL rst_execStrobe got=%b exp=0", execStrobe); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (ir !== 8'h00) begin bad++; $display("FAIL rst_ir got=%h exp=00", ir); end
    total++; if (operand !== 8'h00) begin bad++; $display("FAIL rst_operand got=%h exp=00", operand); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", pc); end
  endtask

  task automatic test_single_and_halt();
    clear_rom();
    rom[8'h00] = 8'h05; rom[8'h01] = 8'h7F;
    do_reset();
    total++; if (assertRom !== 1'b1 || pcResetBar !== 1'b1) begin bad++; $display("FAIL s1_fetch assertRom=%b pcResetBar=%b exp=1,1", assertRom, pcResetBar); end
    step();
    total++; if (ir !== 8'h05) begin bad++; $display("FAIL s1_ir got=%h exp=05", ir); end
    total++; if (execStrobe !== 1'b1 || assertRom !== 1'b0) begin bad++; $display("FAIL s1_exec execStrobe=%b assertRom=%b exp=1,0", execStrobe, assertRom); end
    total++; if (pc !== 8'h01) begin bad++; $display("FAIL s1_pc got=%h exp=01", pc); end
    step();
    total++; if (assertRom !== 1'b1 || execStrobe !== 1'b0) begin bad++; $display("FAIL s1_fetch2 assertRom=%b execStrobe=%b exp=1,0", assertRom, execStrobe); end
    step();
    total++; if (ir !== 8'h7F) begin bad++; $display("FAIL s1_ir_halt got=%h exp=7F", ir); end
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (halted !== 1'b1 || pc !== 8'h02 || assertRom !== 1'b0) begin bad++; $display("FAIL s1_halt_%0d halted=%b pc=%h assertRom=%b exp=1,02,0", i, halted, pc, assertRom); end
    end
    stall = 1'b0;
  endtask

  task automatic test_immediate();
    clear_rom();
    rom[8'h00] = 8'h8A; rom[8'h01] = 8'h3C; rom[8'h02] = 8'h7F;
    do_reset();
    step();
    total++; if (ir !== 8'h8A || pc !== 8'h01) begin bad++; $display("FAIL imm_c2 ir=%h pc=%h exp=8A,01", ir, pc); end
    total++; if (assertRom !== 1'b1 || doJumpBar !== 1'b1 || execStrobe !== 1'b0) begin bad++; $display("FAIL imm_c2_ctl assertRom=%b doJumpBar=%b execStrobe=%b exp=1,1,0", assertRom, doJumpBar, execStrobe); end
    step();
    total++; if (operand !== 8'h3C || pc !== 8'h02) begin bad++; $display("FAIL imm_c3 operand=%h pc=%h exp=3C,02", operand, pc); end
    total++; if (execStrobe !== 1'b1 || assertRom !== 1'b0) begin bad++; $display("FAIL imm_c3_ctl execStrobe=%b assertRom=%b exp=1,0", execStrobe, assertRom); end
    step();
    total++; if (assertRom !== 1'b1 || pc !== 8'h02) begin bad++; $display("FAIL imm_next assertRom=%b pc=%h exp=1,02", assertRom, pc); end
  endtask

  // Sequence: 00: C0 10 -> 10: D0 40 (jump if Z) -> ...
  task automatic load_jump_rom();
    clear_rom();
    rom[8'h00] = 8'hC0; rom[8'h01] = 8'h10;
    rom[8'h10] = 8'hD0; rom[8'h11] = 8'h40;
    rom[8'h12] = 8'hF0; rom[8'h13] = 8'h60;
    rom[8'h40] = 8'hE0; rom[8'h41] = 8'h50;
  endtask

  task automatic test_jump();
    load_jump_rom();
    do_reset();
    flagZ = 1'b1; flagC = 1'b1;
    step();
    total++; if (doJumpBar !== 1'b0 || assertRom !== 1'b1) begin bad++; $display("FAIL jmp_always doJumpBar=%b assertRom=%b exp=0,1", doJumpBar, assertRom); end
    step();
    total++; if (pc !== 8'h10) begin bad++; $display("FAIL jmp_always_pc got=%h exp=10", pc); end
    step();
    total++; if (doJumpBar !== 1'b0) begin bad++; $display("FAIL jmp_z_taken doJumpBar=%b exp=0", doJumpBar); end
    step();
    total++; if (pc !== 8'h40 || doJumpBar !== 1'b1 || assertRom !== 1'b1) begin bad++; $display("FAIL jmp_z_taken_pc pc=%h doJumpBar=%b assertRom=%b exp=40,1,1", pc, doJumpBar, assertRom); end
    step(); step();
    total++; if (pc !== 8'h50 || operand !== 8'h50) begin bad++; $display("FAIL jmp_c_taken pc=%h operand=%h exp=50,50", pc, operand); end

    do_reset();
    step(); step();
    flagZ = 1'b0; flagC = 1'b0;
    step();
    total++; if (doJumpBar !== 1'b1 || assertRom !== 1'b1) begin bad++; $display("FAIL jmp_z_not doJumpBar=%b assertRom=%b exp=1,1", doJumpBar, assertRom); end
    step();
    total++; if (pc !== 8'h12 || assertRom !== 1'b1) begin bad++; $display("FAIL jmp_z_not_pc pc=%h assertRom=%b exp=12,1", pc, assertRom); end
    step();
    total++; if (doJumpBar !== 1'b0) begin bad++; $display("FAIL jmp_nz_taken doJumpBar=%b exp=0", doJumpBar); end
    step();
    total++; if (pc !== 8'h60) begin bad++; $display("FAIL jmp_nz_pc got=%h exp=60", pc); end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[8'h00] = 8'hC0; rom[8'h01] = 8'hFE;
    rom[8'hFE] = 8'hC0; rom[8'hFF] = 8'h00;
    do_reset();
    step(); step();
    total++; if (pc !== 8'hFE) begin bad++; $display("FAIL wrap_at_fe got=%h exp=FE", pc); end
    step();
    total++; if (pc !== 8'hFF || doJumpBar !== 1'b0) begin bad++; $display("FAIL wrap_jmp pc=%h doJumpBar=%b exp=FF,0", pc, doJumpBar); end
    step();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL wrap_jmp_target got=%h exp=00", pc); end

    clear_rom();
    rom[8'h00] = 8'hC0; rom[8'h01] = 8'hFF;
    do_reset();
    step(); step();
    total++; if (pc !== 8'hFF || assertRom !== 1'b1) begin bad++; $display("FAIL wrap_at_ff pc=%h assertRom=%b exp=FF,1", pc, assertRom); end
    step();
    total++; if (pc !== 8'h00 || ir !== 8'h00 || execStrobe !== 1'b1) begin bad++; $display("FAIL wrap_incr pc=%h ir=%h execStrobe=%b exp=00,00,1", pc, ir, execStrobe); end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[8'h00] = 8'h8A; rom[8'h01] = 8'h3C; rom[8'h02] = 8'h7F;
    do_reset();
    step();
    stall = 1'b1;
    #1;
    total++; if (assertRom !== 1'b0 || doJumpBar !== 1'b1 || execStrobe !== 1'b0) begin bad++; $display("FAIL stl_ctl assertRom=%b doJumpBar=%b execStrobe=%b exp=0,1,0", assertRom, doJumpBar, execStrobe); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 8'h01 || ir !== 8'h8A || operand !== 8'h00 || assertRom !== 1'b0) begin bad++; $display("FAIL stl_hold_%0d pc=%h ir=%h operand=%h assertRom=%b exp=01,8A,00,0", i, pc, ir, operand, assertRom); end
    end
    stall = 1'b0;
    #1;
    total++; if (assertRom !== 1'b1) begin bad++; $display("FAIL stl_resume assertRom=%b exp=1", assertRom); end
    step();
    total++; if (operand !== 8'h3C || pc !== 8'h02 || execStrobe !== 1'b1) begin bad++; $display("FAIL stl_after operand=%h pc=%h execStrobe=%b exp=3C,02,1", operand, pc, execStrobe); end
    stall = 1'b1;
    #1;
    total++; if (execStrobe !== 1'b0) begin bad++; $display("FAIL stl_exec execStrobe=%b exp=0", execStrobe); end
    step();
    stall = 1'b0;
    #1;
    total++; if (execStrobe !== 1'b1 || pc !== 8'h02) begin bad++; $display("FAIL stl_exec_resume execStrobe=%b pc=%h exp=1,02", execStrobe, pc); end

    clear_rom();
    rom[8'h00] = 8'hC0; rom[8'h01] = 8'h20;
    do_reset();
    step();
    stall = 1'b1;
    #1;
    total++; if (doJumpBar !== 1'b1 || assertRom !== 1'b0) begin bad++; $display("FAIL stl_jump doJumpBar=%b assertRom=%b exp=1,0", doJumpBar, assertRom); end
    step();
    stall = 1'b0;
    step();
    total++; if (pc !== 8'h20) begin bad++; $display("FAIL stl_jump_after pc=%h exp=20", pc); end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[8'h00] = 8'h05; rom[8'h01] = 8'h7F;
    do_reset();
    step();
    total++; if (execStrobe !== 1'b1) begin bad++; $display("FAIL rm_exec execStrobe=%b exp=1", execStrobe); end
    reset = 1'b1;
    #1;
    total++; if (pcResetBar !== 1'b0 || execStrobe !== 1'b0 || assertRom !== 1'b0) begin bad++; $display("FAIL rm_exec_rst pcResetBar=%b execStrobe=%b assertRom=%b exp=0,0,0", pcResetBar, execStrobe, assertRom); end
    step();
    reset = 1'b0;
    #1;
    total++; if (pc !== 8'h00 || ir !== 8'h00 || assertRom !== 1'b1) begin bad++; $display("FAIL rm_exec_after pc=%h ir=%h assertRom=%b exp=00,00,1", pc, ir, assertRom); end
    step(); step(); step();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL rm_halt halted=%b exp=1", halted); end
    reset = 1'b1; stall = 1'b1;
    #1;
    total++; if (halted !== 1'b0 || pcResetBar !== 1'b0) begin bad++; $display("FAIL rm_halt_rst halted=%b pcResetBar=%b exp=0,0", halted, pcResetBar); end
    step();
    reset = 1'b0; stall = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || assertRom !== 1'b1 || pc !== 8'h00 || ir !== 8'h00) begin bad++; $display("FAIL rm_halt_after halted=%b assertRom=%b pc=%h ir=%h exp=0,1,00,00", halted, assertRom, pc, ir); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flagZ = 1'b0; flagC = 1'b0;
    test_reset();
    test_single_and_halt();
    test_immediate();
    test_jump();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
